commit_arbiter: RTL and testbench

Write-back stage downstream of the execution ALUs (ALU 0 … ALU N-1, including the memory ALU). Each cycle it selects at most one ALU holding a valid result and acknowledges that ALU with a one-cycle `clear` pulse. It registers the result onto the register-file write port and counts retirements. An ALU reporting an error is converted into a trap request that halts commit until the trap is acknowledged.

---
 rtl/commit_arbiter.sv | 177 +++++++++++++++++
 tb/tb_commit_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/commit_arbiter.sv
// commit_arbiter: write-back stage after the execution ALUs.
// Each cycle it picks at most one ALU that holds a valid result. The pick is
// round-robin. The chosen ALU gets a one-cycle clear pulse, and its result is
// registered onto the register-file write port. An ALU that reports an error
// turns into a trap, and commit stops until the trap is acknowledged.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   alu_valid/err     per-ALU result valid / error flag (err qualified by valid)
//   alu_res, alu_rd   flattened per-ALU result data / destination register
//   alu_clear         acknowledge: one-hot grant, or all valid ALUs on flush
//   flush             discard every pending result, reset the search pointer
//   rf_we/waddr/wdata registered register-file write port
//   trap, trap_src    error pending and the index of the faulting ALU
//   trap_ack          trap handled, resume commit
//   retire_count      committed results, wraps at 2^32

package core_config_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
endpackage

module commit_arbiter #(
    parameter int N_ALU      = 6,
    parameter int XLEN       = core_config_pkg::XLEN,
    parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W,
    localparam int IDX_W     = (N_ALU > 1) ? $clog2(N_ALU) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_ALU-1:0]            alu_valid,
    input  logic [N_ALU*XLEN-1:0]       alu_res,
    input  logic [N_ALU*REG_ADDR_W-1:0] alu_rd,
    input  logic [N_ALU-1:0]            alu_err,
    output logic [N_ALU-1:0]            alu_clear,
    input  logic                        flush,
    output logic                        rf_we,
    output logic [REG_ADDR_W-1:0]       rf_waddr,
    output logic [XLEN-1:0]             rf_wdata,
    output logic                        trap,
    output logic [IDX_W-1:0]            trap_src,
    input  logic                        trap_ack,
    output logic [31:0]                 retire_count
);

    typedef enum logic {S_RUN, S_TRAP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        trap_src_q, trap_src_d;
    logic                    rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]         rf_wdata_q, rf_wdata_d;
    logic [31:0]             retire_q, retire_d;

    logic [N_ALU-1:0][XLEN-1:0]       res_arr;
    logic [N_ALU-1:0][REG_ADDR_W-1:0] rd_arr;
    logic                    grant_any;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_en;
    logic                    grant_err;
    logic [XLEN-1:0]         grant_res;
    logic [REG_ADDR_W-1:0]   grant_rd;
    logic [IDX_W-1:0]        ptr_next;

    assign res_arr = alu_res;
    assign rd_arr  = alu_rd;

    // Round-robin search. It starts at ptr_q, moves upward and wraps to 0.
    // The first valid index it finds is the grant.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < N_ALU; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_ALU) idx = idx - N_ALU;
            if (!grant_any && alu_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

    assign grant_err = alu_err[grant_idx];
    assign grant_res = res_arr[grant_idx];
    assign grant_rd  = rd_arr[grant_idx];
    assign ptr_next  = (grant_idx == IDX_W'(N_ALU - 1)) ? '0 : grant_idx + 1'b1;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    // FSM next state: flush beats everything, including trap_ack
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN:   if (grant_en && grant_err) state_d = S_TRAP;
                S_TRAP:  if (trap_ack)              state_d = S_RUN;
                default: state_d = S_RUN;
            endcase
        end
    end

    // FSM outputs. The clear is combinational, so it is gated by reset:
    // a grant that is pending when reset hits never acknowledges the ALU.
    always_comb begin
        alu_clear = '0;
        grant_en  = 1'b0;
        if (rst_n) begin
            if (flush) begin
                alu_clear = alu_valid;
            end else if (state_q == S_RUN && grant_any) begin
                grant_en             = 1'b1;
                alu_clear[grant_idx] = 1'b1;
            end
        end
    end

    assign trap = (state_q == S_TRAP);

    // Datapath next values. The write port holds its address and data
    // between commits. Only rf_we pulses.
    always_comb begin
        ptr_d      = ptr_q;
        trap_src_d = trap_src_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        retire_d   = retire_q;
        if (flush) begin
            ptr_d = '0;
        end else if (grant_en) begin
            ptr_d = ptr_next;
            if (grant_err) begin
                trap_src_d = grant_idx;
            end else begin
                // A write to x0 still counts as a retirement, but it does not write.
                rf_we_d    = |grant_rd;
                rf_waddr_d = grant_rd;
                rf_wdata_d = grant_res;
                retire_d   = retire_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            trap_src_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            retire_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            trap_src_q <= trap_src_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            retire_q   <= retire_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign trap_src     = trap_src_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed bench for commit_arbiter. The stimulus pushes each expected
// register-file write into a queue. A negedge monitor pops and compares
// every write the DUT presents.
module tb_commit_arbiter;
    localparam int N  = 6;
    localparam int XL = 32;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    alu_valid, alu_err, alu_clear;
    logic [N*XL-1:0] alu_res;
    logic [N*RW-1:0] alu_rd;
    logic            flush, rf_we, trap, trap_ack;
    logic [RW-1:0]   rf_waddr;
    logic [XL-1:0]   rf_wdata;
    logic [2:0]      trap_src;
    logic [31:0]     retire_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [RW-1:0] a; logic [XL-1:0] d; } wr_t;
    wr_t exp_q[$];

    commit_arbiter #(.N_ALU(N), .XLEN(XL), .REG_ADDR_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_res(alu_res),
        .alu_rd(alu_rd), .alu_err(alu_err), .alu_clear(alu_clear), .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .trap(trap),
        .trap_src(trap_src), .trap_ack(trap_ack), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_alu(input int i, input logic [RW-1:0] rd, input logic [XL-1:0] res,
                           input logic err);
        alu_valid[i]        = 1'b1;
        alu_rd[i*RW +: RW]  = rd;
        alu_res[i*XL +: XL] = res;
        alu_err[i]          = err;
    endtask

    task automatic push(input logic [RW-1:0] a, input logic [XL-1:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // One cycle. Check the clear pulse mid-cycle. The ALUs then drop the
    // results that were acknowledged.
    task automatic cyc(input string name, input logic [N-1:0] exp_clr);
        logic [N-1:0] clr;
        @(negedge clk);
        chk(name, 64'(alu_clear), 64'(exp_clr));
        clr = alu_clear;
        @(posedge clk);
        #1;
        alu_valid = alu_valid & ~clr;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h:%0h expected=none", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("rf_write", 64'({rf_waddr, rf_wdata}), 64'({e.a, e.d}));
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; trap_ack = 1'b0;
        alu_valid = '1; alu_err = '0; alu_res = '0; alu_rd = '0;
        // Reset values. The clear stays gated while valids are pending.
        @(negedge clk);
        chk("rst_clear", 64'(alu_clear), 64'd0);
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_trap", 64'(trap), 64'd0);
        chk("rst_src", 64'(trap_src), 64'd0);
        chk("rst_count", 64'(retire_count), 64'd0);
        chk("rst_waddr", 64'({rf_waddr, rf_wdata}), 64'd0);
        @(posedge clk); #1;
        alu_valid = '0; rst_n = 1'b1;

        // Single result
        set_alu(2, 5'd5, 32'hDEADBEEF, 1'b0);
        push(5'd5, 32'hDEADBEEF);
        cyc("single_clear", 6'b000100);
        chk("single_count", 64'(retire_count), 64'd1);

        // A flush with nothing pending only resets the pointer
        flush = 1'b1;
        cyc("flush_empty", 6'b000000);
        flush = 1'b0;
        chk("flush_empty_count", 64'(retire_count), 64'd1);

        // Round-robin from ptr=0
        for (int i = 0; i < N; i++) set_alu(i, RW'(i + 10), 32'h100 + i, 1'b0);
        for (int i = 0; i < N; i++) begin
            push(RW'(i + 10), 32'h100 + i);
            cyc("rr_clear", 6'(1 << i));
        end
        chk("rr_count", 64'(retire_count), 64'd7);

        // Destination x0: the result is cleared and counted, with no write
        set_alu(1, 5'd0, 32'h1234, 1'b0);
        cyc("x0_clear", 6'b000010);
        chk("x0_we", 64'(rf_we), 64'd0);
        chk("x0_count", 64'(retire_count), 64'd8);

        // Move ptr to 3
        set_alu(2, 5'd7, 32'h77, 1'b0);
        push(5'd7, 32'h77);
        cyc("ptr3_clear", 6'b000100);

        // Error trap with ptr=3: ALU4 wins over ALU0
        set_alu(0, 5'd3, 32'hA0A0, 1'b0);
        set_alu(4, 5'd6, 32'hBAD, 1'b1);
        cyc("err_clear", 6'b010000);
        alu_err[4] = 1'b0;
        chk("err_trap", 64'(trap), 64'd1);
        chk("err_src", 64'(trap_src), 64'd4);
        chk("err_we", 64'(rf_we), 64'd0);
        chk("err_count", 64'(retire_count), 64'd9);
        cyc("trap_hold", 6'b000000);
        chk("trap_hold_trap", 64'(trap), 64'd1);
        trap_ack = 1'b1;
        cyc("trap_ack_cycle", 6'b000000);
        trap_ack = 1'b0;
        chk("ack_trap", 64'(trap), 64'd0);
        push(5'd3, 32'hA0A0);
        cyc("after_ack_clear", 6'b000001);
        chk("after_ack_count", 64'(retire_count), 64'd10);

        // Trap again (ptr=1 picks ALU3), then flush while in TRAP
        set_alu(3, 5'd8, 32'h88, 1'b1);
        cyc("err2_clear", 6'b001000);
        alu_err[3] = 1'b0;
        chk("err2_src", 64'(trap_src), 64'd3);
        set_alu(1, 5'd11, 32'h1111, 1'b0);
        set_alu(3, 5'd13, 32'h3333, 1'b0);
        flush = 1'b1;
        cyc("flush_trap_clear", 6'b001010);
        flush = 1'b0;
        chk("flush_trap", 64'(trap), 64'd0);
        chk("flush_we", 64'(rf_we), 64'd0);
        chk("flush_count", 64'(retire_count), 64'd10);
        // With ptr back at 0, ALU1 goes ahead of ALU5
        set_alu(1, 5'd11, 32'h1111, 1'b0);
        set_alu(5, 5'd15, 32'h5555, 1'b0);
        push(5'd11, 32'h1111);
        cyc("ptr0_first", 6'b000010);
        push(5'd15, 32'h5555);
        cyc("ptr0_second", 6'b100000);
        chk("ptr0_count", 64'(retire_count), 64'd12);

        // trap_ack in RUN is ignored
        set_alu(2, 5'd2, 32'h22, 1'b0);
        trap_ack = 1'b1;
        push(5'd2, 32'h22);
        cyc("ack_run_clear", 6'b000100);
        trap_ack = 1'b0;
        chk("ack_run_trap", 64'(trap), 64'd0);

        // A flush does not cancel a write that is already registered
        set_alu(3, 5'd4, 32'h44, 1'b0);
        push(5'd4, 32'h44);
        cyc("pre_flush_clear", 6'b001000);
        set_alu(1, 5'd1, 32'h11, 1'b0);
        flush = 1'b1;
        cyc("flush_pend_clear", 6'b000010);
        flush = 1'b0;
        chk("flush_pend_count", 64'(retire_count), 64'd14);
        chk("flush_pend_we", 64'(rf_we), 64'd0);

        // Reset asserted while a write is registered
        set_alu(4, 5'd9, 32'h99, 1'b0);
        cyc("rst_mid_clear", 6'b010000);
        chk("rst_mid_we_before", 64'(rf_we), 64'd1);
        chk("rst_mid_count_before", 64'(retire_count), 64'd15);
        set_alu(2, 5'd2, 32'h2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 64'(rf_we), 64'd0);
        chk("rst_mid_count", 64'(retire_count), 64'd0);
        chk("rst_mid_clear_gated", 64'(alu_clear), 64'd0);
        @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
